dmem_resp: RTL and testbench

Data-memory responder for the Tiny RISC-V core. It sits on the far side of the execute stage's RAM request port: `en_ram`, `wre_ram`, `addr_ram`, `data_ram`, plus the load/store `funct3`. It owns a single-port, synchronous-read word SRAM and serves byte, halfword and word loads and stores. Sub-word stores are done as a read-modify-write, and load results are returned already zero- or sign-extended for writeback.

---
 rtl/dmem_pkg.sv | 69 ++++++
 rtl/dmem_resp_if.sv | 23 ++
 rtl/dmem_sram.sv | 20 ++
 rtl/dmem_resp.sv | 106 ++++++++++
 tb/tb_dmem_resp.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 codes, FSM states and lane helpers for the data-memory responder
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MERGE = 2'd2
  } state_t;

  // Pick the addressed byte/halfword out of a word and extend it for writeback
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'b0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a word with the low bits of the store data
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  addr_lo,
                                             input logic [2:0]  f3);
    logic [31:0] r;
    r = word;
    if (f3 == F3_B) begin
      r[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    end else if (f3 == F3_H) begin
      if (addr_lo[1]) r[31:16] = wdata[15:0];
      else            r[15:0]  = wdata[15:0];
    end else begin
      r = wdata;
    end
    return r;
  endfunction

  // True when the access is misaligned or the funct3/direction pair is illegal
  function automatic logic req_bad(input logic       wre,
                                   input logic [1:0] addr_lo,
                                   input logic [2:0] f3);
    logic r;
    case (f3)
      F3_B:    r = 1'b0;
      F3_H:    r = addr_lo[0];
      F3_W:    r = (addr_lo != 2'b00);
      F3_BU:   r = wre;
      F3_HU:   r = wre | addr_lo[0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - request/response bundle between execute stage and data memory
interface dmem_resp_if;
  logic        en_ram;
  logic        wre_ram;
  logic [31:0] addr_ram;
  logic [31:0] data_ram;
  logic [2:0]  funct3;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        wdone;
  logic        misalign;

  modport master (
    output en_ram, wre_ram, addr_ram, data_ram, funct3,
    input  ready, rdata, rvalid, wdone, misalign
  );

  modport slave (
    input  en_ram, wre_ram, addr_ram, data_ram, funct3,
    output ready, rdata, rvalid, wdone, misalign
  );
endinterface

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port word array with registered read data
module dmem_sram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Write on request; read returns the pre-write word one cycle later
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data-memory responder: sub-word load extension and read-modify-write stores
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  dmem_resp_if.slave bus
);

  state_t        state;
  logic [AW-1:0] widx_q;
  logic [1:0]    lo_q;
  logic [2:0]    f3_q;
  logic [15:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic          wdone_q;
  logic          misalign_q;

  logic          accept;
  logic          bad;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          unused_addr_hi;

  assign accept         = (state == S_IDLE) && bus.en_ram;
  assign bad            = req_bad(bus.wre_ram, bus.addr_ram[1:0], bus.funct3);
  assign unused_addr_hi = ^bus.addr_ram[31:AW+2];

  assign bus.ready    = (state == S_IDLE);
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.wdone    = wdone_q;
  assign bus.misalign = misalign_q;

  // Array port: live request address in IDLE, captured address otherwise; writes are dropped under reset
  always_comb begin
    sram_addr  = (state == S_IDLE) ? bus.addr_ram[AW+1:2] : widx_q;
    sram_we    = 1'b0;
    sram_wdata = bus.data_ram;
    if (rst_n) begin
      if (state == S_MERGE) begin
        sram_we    = 1'b1;
        sram_wdata = lane_merge(sram_rdata, {16'b0, wdata_q}, lo_q, f3_q);
      end else if (accept && !bad && bus.wre_ram && bus.funct3 == F3_W) begin
        sram_we = 1'b1;
      end
    end
  end

  dmem_sram #(.AW(AW)) u_sram (
    .clk   (clk),
    .addr  (sram_addr),
    .we    (sram_we),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  // Control FSM with request capture and registered response pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      widx_q     <= '0;
      lo_q       <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      wdone_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rvalid_q   <= 1'b0;
      wdone_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            widx_q  <= bus.addr_ram[AW+1:2];
            lo_q    <= bus.addr_ram[1:0];
            f3_q    <= bus.funct3;
            wdata_q <= bus.data_ram[15:0];
            if (bad)                      misalign_q <= 1'b1;
            else if (!bus.wre_ram)        state      <= S_LOAD;
            else if (bus.funct3 == F3_W)  wdone_q    <= 1'b1;
            else                          state      <= S_MERGE;
          end
        end
        S_LOAD: begin
          rdata_q  <= lane_extract(sram_rdata, lo_q, f3_q);
          rvalid_q <= 1'b1;
          state    <= S_IDLE;
        end
        S_MERGE: begin
          wdone_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed table-driven bench for the data-memory responder
module tb_dmem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  dmem_resp_if bus ();

  dmem_resp #(.AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wre;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    int          kind;   // 0 rvalid, 1 wdone, 2 misalign
    int          lat;    // samples after the accept edge
    logic [31:0] exp;
  } vec_t;

  vec_t vt [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, pulses, kind, multi;
    logic [31:0] got;
    @(negedge clk);
    bus.en_ram   = 1'b1;
    bus.wre_ram  = v.wre;
    bus.addr_ram = v.addr;
    bus.data_ram = v.data;
    bus.funct3   = v.f3;
    for (int i = 0; i < 10 && !bus.ready; i++) @(negedge clk);
    check($sformatf("v%0d_ready", idx), {31'b0, bus.ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.en_ram = 1'b0;
    lat = 0; pulses = 0; kind = 3; multi = 0; got = 32'hx;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (int'(bus.rvalid) + int'(bus.wdone) + int'(bus.misalign) > 1) multi = 1;
      if (bus.rvalid || bus.wdone || bus.misalign) begin
        pulses++;
        if (lat == 0) begin
          lat  = c;
          kind = bus.rvalid ? 0 : (bus.wdone ? 1 : 2);
          got  = bus.rdata;
        end
      end
    end
    check($sformatf("v%0d_kind", idx), kind, v.kind);
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_pulses", idx), pulses, 1);
    check($sformatf("v%0d_exclusive", idx), multi, 0);
    if (v.kind == 0) check($sformatf("v%0d_rdata", idx), got, v.exp);
  endtask

  initial begin
    bus.en_ram = 1'b0; bus.wre_ram = 1'b0; bus.addr_ram = '0; bus.data_ram = '0; bus.funct3 = '0;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 1, 1, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 0, 2, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h0000_0013, 32'h0000_0080, 3'b000, 1, 2, 32'h0};
    vt[3]  = '{1'b0, 32'h0000_0013, 32'h0,         3'b000, 0, 2, 32'hFFFF_FF80};
    vt[4]  = '{1'b0, 32'h0000_0013, 32'h0,         3'b100, 0, 2, 32'h0000_0080};
    vt[5]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 0, 2, 32'h80AD_BEEF};
    vt[6]  = '{1'b1, 32'h0000_0012, 32'h1234_8001, 3'b001, 1, 2, 32'h0};
    vt[7]  = '{1'b0, 32'h0000_0012, 32'h0,         3'b001, 0, 2, 32'hFFFF_8001};
    vt[8]  = '{1'b0, 32'h0000_0012, 32'h0,         3'b101, 0, 2, 32'h0000_8001};
    vt[9]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b101, 0, 2, 32'h0000_BEEF};
    vt[10] = '{1'b0, 32'h0000_0011, 32'h0,         3'b010, 2, 1, 32'h0};
    vt[11] = '{1'b1, 32'h0000_0021, 32'hFFFF_FFFF, 3'b001, 2, 1, 32'h0};
    vt[12] = '{1'b0, 32'h0000_0010, 32'h0,         3'b011, 2, 1, 32'h0};
    vt[13] = '{1'b1, 32'h0000_0010, 32'h0000_0011, 3'b100, 2, 1, 32'h0};
    vt[14] = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 0, 2, 32'h8001_BEEF};
    vt[15] = '{1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 3'b010, 1, 1, 32'h0};
    vt[16] = '{1'b0, 32'h0000_0000, 32'h0,         3'b010, 0, 2, 32'h5A5A_5A5A};
    vt[17] = '{1'b1, 32'h0000_0011, 32'h0000_007F, 3'b000, 1, 2, 32'h0};
    vt[18] = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 0, 2, 32'h8001_7FEF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    {31'b0, bus.ready},    32'd1);
    check("rst_rdata",    bus.rdata,             32'h0);
    check("rst_rvalid",   {31'b0, bus.rvalid},   32'd0);
    check("rst_wdone",    {31'b0, bus.wdone},    32'd0);
    check("rst_misalign", {31'b0, bus.misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(vt[i], i);

    // Reset while in MERGE: no wdone, no array write
    @(negedge clk);
    bus.en_ram = 1'b1; bus.wre_ram = 1'b1; bus.addr_ram = 32'h10; bus.data_ram = 32'hAA; bus.funct3 = 3'b000;
    @(posedge clk);
    #1;
    bus.en_ram = 1'b0;
    rst_n = 1'b0;
    check("mrst_state_merge", {31'b0, bus.ready}, 32'd0);
    @(posedge clk);
    #1;
    check("mrst_wdone_a", {31'b0, bus.wdone}, 32'd0);
    check("mrst_ready",   {31'b0, bus.ready}, 32'd1);
    check("mrst_rdata",   bus.rdata,          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_wdone_b", {31'b0, bus.wdone}, 32'd0);
    run_vec('{1'b0, 32'h10, 32'h0, 3'b010, 0, 2, 32'h8001_7FEF}, 100);

    // en_ram held while LOAD is in progress: accepted once, on the first ready cycle
    @(negedge clk);
    bus.en_ram = 1'b1; bus.wre_ram = 1'b0; bus.addr_ram = 32'h10; bus.funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    bus.addr_ram = 32'h0;
    check("hold_ready_low", {31'b0, bus.ready}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_rvalid1", {31'b0, bus.rvalid}, 32'd1);
    check("hold_rdata1",  bus.rdata,           32'h8001_7FEF);
    @(posedge clk);
    #1;
    bus.en_ram = 1'b0;
    check("hold_rvalid_gap", {31'b0, bus.rvalid}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_rvalid2", {31'b0, bus.rvalid}, 32'd1);
    check("hold_rdata2",  bus.rdata,           32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    check("hold_no_extra", {31'b0, bus.rvalid}, 32'd0);
    check("hold_rdata_kept", bus.rdata, 32'h5A5A_5A5A);

    // Back-to-back SW: wdone on consecutive cycles, later words readable
    @(negedge clk);
    bus.en_ram = 1'b1; bus.wre_ram = 1'b1; bus.funct3 = 3'b010;
    bus.addr_ram = 32'h20; bus.data_ram = 32'h1111_2222;
    @(posedge clk);
    #1;
    check("b2b_wdone1", {31'b0, bus.wdone}, 32'd1);
    bus.addr_ram = 32'h24; bus.data_ram = 32'h3333_4444;
    @(posedge clk);
    #1;
    bus.en_ram = 1'b0;
    check("b2b_wdone2", {31'b0, bus.wdone}, 32'd1);
    run_vec('{1'b0, 32'h20, 32'h0, 3'b010, 0, 2, 32'h1111_2222}, 101);
    run_vec('{1'b0, 32'h26, 32'h0, 3'b001, 0, 2, 32'h0000_3333}, 102);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
